switch_input_unit: RTL
======================

// Module: switch_input_unit
// PURPOSE
//  Input stage upstream of the core's IN path: owns the check-in push button and the 16 slide switches.
//  When the core executes an IN instruction (in_req), the unit stalls the core (halt_req) until a clean debounced press.
//  On that press it latches the switch word and returns it with in_valid; the core's 16-bit input mux/extender consumes in_data.
//  Replaces the free-running debouncer + raw switch wiring with a synchronised, handshaked capture.
// PARAMETERS
//  DATA_W          16      switch word width
//  DEBOUNCE_CYCLES 50000   stable-level cycles before a button level change is accepted (>=2)
//  TIMEOUT_CYCLES  2**24   wait cycles before forced capture (used only with SWITCH_INPUT_TIMEOUT_EN)
// PORTS
//  Clock      in   1       system clock; all state on rising edge
//  n_reset    in   1       asynchronous active-low reset
//  button_n   in   1       raw push button, active-low, asynchronous to Clock
//  switches   in   DATA_W  raw slide switches, asynchronous to Clock
//  in_req     in   1       core is executing IN; level, held until halt_req drops
//  halt_req   out  1       stall request to core while waiting for the press
//  in_valid   out  1       in_data holds a fresh capture for the current IN
//  in_data    out  DATA_W  last captured switch word
//  timed_out  out  1       capture was forced by timeout (0 when feature compiled out)
// BEHAVIOUR
//  Reset (async, n_reset=0): state IDLE; halt_req=0, in_valid=0, in_data=0, timed_out=0; sync flops=1 (button released), counters=0.
//  Sync: button_n and switches each pass 2 flops; all logic uses synced copies only.
//  Debounce: btn_stable resets to 1; counter increments while synced button != btn_stable, clears when equal;
//   at count DEBOUNCE_CYCLES-1 btn_stable takes the new level, counter clears. press = btn_stable 1->0 (one-cycle pulse).
//  FSM (registered outputs, changes visible the cycle after the cause):
//   IDLE:         in_req=1 -> WAIT_RELEASE if btn_stable=0 else WAIT_PRESS; halt_req<=1, in_valid<=0, timed_out<=0.
//   WAIT_RELEASE: btn_stable=1 -> WAIT_PRESS (a press held across IN entry never counts).
//   WAIT_PRESS:   press -> in_data<=synced switches, in_valid<=1, halt_req<=0, -> DONE.
//   DONE:         in_valid held 1 until in_req=0 -> IDLE, in_valid<=0. New presses ignored.
//   in_req=0 in WAIT_RELEASE/WAIT_PRESS: abort -> IDLE, halt_req<=0, in_data unchanged, no in_valid.
//  Latency: press pulse at cycle N -> in_valid=1, halt_req=0 at N+1; raw edge -> press >= 2+DEBOUNCE_CYCLES cycles.
//  Simultaneous press and in_req drop in WAIT_PRESS: abort wins, no capture.
//  in_data stable between captures; only WAIT_PRESS capture (or timeout) writes it.
// CONFIGURATION
//  SWITCH_INPUT_TIMEOUT_EN defined: wait counter clears on IDLE exit, counts in WAIT_RELEASE/WAIT_PRESS;
//   at TIMEOUT_CYCLES-1 force capture of synced switches, in_valid<=1, timed_out<=1, halt_req<=0, -> DONE.
//   timed_out cleared on next IDLE exit or reset. Press and expiry same cycle: press wins, timed_out=0.
//  Undefined: no wait counter; timed_out tied 0; unit waits indefinitely.
// STRUCTURE
//  Package jups_io_pkg: state enum {IDLE, WAIT_RELEASE, WAIT_PRESS, DONE}, JUPS_IO_DATA_W=16.
//  Sub-module switch_input_debounce: 2-flop sync + debounce counter, outputs btn_stable and press.
//  Top: switch 2-flop sync, FSM, capture register, optional timeout counter.
// TESTING (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64 in bench)
//  Reset mid-WAIT_PRESS with switches=16'hBEEF -> all outputs 0 immediately, IDLE after release, no capture.
//  in_req=1, switches=16'h00A5, clean press -> halt_req 1 until press, then in_valid=1, in_data=16'h00A5, halt_req=0.
//  Button bouncing 1-cycle glitches for 20 cycles then released -> no press, halt_req stays 1, in_data unchanged.
//  Button held low before in_req -> no capture until release then new press; captured word = switches at 2nd press.
//  in_req dropped in WAIT_PRESS with press pulse same cycle -> IDLE, in_valid=0, in_data keeps prior value.
//  With SWITCH_INPUT_TIMEOUT_EN, no press, switches=16'h1234 -> after 64 wait cycles in_valid=1, timed_out=1, in_data=16'h1234.

Source files
------------

// File: rtl/jups_io_pkg.sv
// rtl/jups_io_pkg.sv - shared types and widths for the switch input unit
package jups_io_pkg;

   localparam int JUPS_IO_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_RELEASE = 2'd1,
      WAIT_PRESS   = 2'd2,
      DONE         = 2'd3
   } sw_in_state_e;

endpackage

// File: rtl/switch_input_debounce.sv
// rtl/switch_input_debounce.sv - button synchroniser and debouncer with press pulse
module switch_input_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic Clock,
   input  logic n_reset,
   input  logic button_n,
   output logic btn_stable,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_meta;
   logic             btn_sync;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchroniser; resets to the released level so no false press at start-up.
   always_ff @(posedge Clock or negedge n_reset) begin
      if (!n_reset) begin
         btn_meta <= 1'b1;
         btn_sync <= 1'b1;
      end else begin
         btn_meta <= button_n;
         btn_sync <= btn_meta;
      end
   end

   // Accept a new level only after it has differed from the stable level for DEBOUNCE_CYCLES cycles;
   // press pulses in the same cycle btn_stable falls to 0.
   always_ff @(posedge Clock or negedge n_reset) begin
      if (!n_reset) begin
         btn_stable <= 1'b1;
         cnt        <= '0;
         press      <= 1'b0;
      end else begin
         press <= 1'b0;
         if (btn_sync == btn_stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            btn_stable <= btn_sync;
            cnt        <= '0;
            press      <= ~btn_sync;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_input_unit.sv
// rtl/switch_input_unit.sv - handshaked IN capture of switches on debounced press (option SWITCH_INPUT_TIMEOUT_EN)
module switch_input_unit
   import jups_io_pkg::*;
#(
   parameter int DATA_W          = JUPS_IO_DATA_W,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int TIMEOUT_CYCLES  = 2**24
) (
   input  logic              Clock,
   input  logic              n_reset,
   input  logic              button_n,
   input  logic [DATA_W-1:0] switches,
   input  logic              in_req,
   output logic              halt_req,
   output logic              in_valid,
   output logic [DATA_W-1:0] in_data,
   output logic              timed_out
);

   sw_in_state_e      state;
   logic [DATA_W-1:0] sw_meta;
   logic [DATA_W-1:0] sw_sync;
   logic              btn_stable;
   logic              press;
   logic              wait_expired;

   switch_input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .Clock     (Clock),
      .n_reset   (n_reset),
      .button_n  (button_n),
      .btn_stable(btn_stable),
      .press     (press)
   );

   // Two-flop synchroniser for the slide switches; only sw_sync is ever captured.
   always_ff @(posedge Clock or negedge n_reset) begin
      if (!n_reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= switches;
         sw_sync <= sw_meta;
      end
   end

`ifdef SWITCH_INPUT_TIMEOUT_EN
   localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   logic [WAIT_W-1:0] wait_cnt;

   assign wait_expired = (wait_cnt == WAIT_LAST);

   // Wait counter: held clear while idle, counts every cycle spent waiting for the press.
   always_ff @(posedge Clock or negedge n_reset) begin
      if (!n_reset) begin
         wait_cnt <= '0;
      end else if (state == WAIT_RELEASE || state == WAIT_PRESS) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end
`else
   assign wait_expired = 1'b0;
   // Timeout compiled out: constant 0, parameter kept so both builds share one interface.
   assign timed_out    = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   // IN handshake FSM with registered outputs; abort (in_req low) takes priority over press and timeout.
   always_ff @(posedge Clock or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         halt_req <= 1'b0;
         in_valid <= 1'b0;
         in_data  <= '0;
`ifdef SWITCH_INPUT_TIMEOUT_EN
         timed_out <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_req) begin
                  state    <= btn_stable ? WAIT_PRESS : WAIT_RELEASE;
                  halt_req <= 1'b1;
                  in_valid <= 1'b0;
`ifdef SWITCH_INPUT_TIMEOUT_EN
                  timed_out <= 1'b0;
`endif
               end
            end
            WAIT_RELEASE, WAIT_PRESS: begin
               if (!in_req) begin
                  state    <= IDLE;
                  halt_req <= 1'b0;
               end else if (state == WAIT_PRESS && press) begin
                  in_data  <= sw_sync;
                  in_valid <= 1'b1;
                  halt_req <= 1'b0;
                  state    <= DONE;
               end else if (wait_expired) begin
                  in_data  <= sw_sync;
                  in_valid <= 1'b1;
                  halt_req <= 1'b0;
                  state    <= DONE;
`ifdef SWITCH_INPUT_TIMEOUT_EN
                  timed_out <= 1'b1;
`endif
               end else if (state == WAIT_RELEASE && btn_stable) begin
                  state <= WAIT_PRESS;
               end
            end
            DONE: begin
               if (!in_req) begin
                  state    <= IDLE;
                  in_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
